// File: rtl/ptw_arbiter.sv
// Two-port page-table-walk arbiter: round-robin between imem and dmem TLBs, one PTE fetch per walk.
// Latency: 3 cycles plus memory wait from request handshake to response pulse; no new request accepted mid-walk.
module ptw_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_ptbr,
  input  logic        io_imem_req_valid,
  output logic        io_imem_req_ready,
  input  logic [29:0] io_imem_req_bits_vpn,
  input  logic        io_dmem_req_valid,
  output logic        io_dmem_req_ready,
  input  logic [29:0] io_dmem_req_bits_vpn,
  output logic        io_mem_req_valid,
  input  logic        io_mem_req_ready,
  output logic [31:0] io_mem_req_bits_addr,
  input  logic        io_mem_resp_valid,
  input  logic [31:0] io_mem_resp_bits_data,
  output logic        io_imem_ptw_resp_valid,
  output logic        io_imem_ptw_resp_bits_error,
  output logic [31:0] io_imem_ptw_resp_bits_ppn,
  output logic        io_dmem_ptw_resp_valid,
  output logic        io_dmem_ptw_resp_bits_error,
  output logic [31:0] io_dmem_ptw_resp_bits_ppn
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  logic        req_id;     // 0 = imem, 1 = dmem
  logic        last_dmem;  // 1 when dmem was granted most recently
  logic        timed_out;
  logic [29:0] vpn;
  logic [31:0] data;
  logic [7:0]  cnt;

  logic gnt_imem, gnt_dmem;
  logic resp_err;
  logic [31:0] resp_ppn;
  logic unused_pte_bits;

  always_comb begin
    gnt_imem = io_imem_req_valid && (!io_dmem_req_valid || last_dmem);
    gnt_dmem = io_dmem_req_valid && (!io_imem_req_valid || !last_dmem);
  end

  // Ready is also masked by reset so nothing handshakes while reset is held.
  assign io_imem_req_ready = (state == IDLE) && !reset && gnt_imem;
  assign io_dmem_req_ready = (state == IDLE) && !reset && gnt_dmem;

  assign io_mem_req_valid     = (state == REQ);
  assign io_mem_req_bits_addr = (state == REQ) ? (io_ptbr + {vpn, 2'b00}) : 32'd0;

  assign resp_err = timed_out || !data[0];
  assign resp_ppn = resp_err ? 32'd0 : {10'd0, data[31:10]};
  assign unused_pte_bits = ^data[9:1];

  always_comb begin
    io_imem_ptw_resp_valid      = (state == RESP) && !req_id;
    io_dmem_ptw_resp_valid      = (state == RESP) && req_id;
    io_imem_ptw_resp_bits_error = io_imem_ptw_resp_valid && resp_err;
    io_dmem_ptw_resp_bits_error = io_dmem_ptw_resp_valid && resp_err;
    io_imem_ptw_resp_bits_ppn   = io_imem_ptw_resp_valid ? resp_ppn : 32'd0;
    io_dmem_ptw_resp_bits_ppn   = io_dmem_ptw_resp_valid ? resp_ppn : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_id    <= 1'b0;
      last_dmem <= 1'b1;
      timed_out <= 1'b0;
      vpn       <= 30'd0;
      data      <= 32'd0;
      cnt       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_imem) begin
            req_id    <= 1'b0;
            vpn       <= io_imem_req_bits_vpn;
            last_dmem <= 1'b0;
            state     <= REQ;
          end else if (gnt_dmem) begin
            req_id    <= 1'b1;
            vpn       <= io_dmem_req_bits_vpn;
            last_dmem <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (io_mem_req_ready) begin
            cnt       <= 8'd0;
            timed_out <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A response in the final counted cycle still beats the timeout.
          if (io_mem_resp_valid) begin
            data  <= io_mem_resp_bits_data;
            state <= RESP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            timed_out <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: a cycle table for basic walks plus hand sequences for the multi-cycle cases.
module tb_ptw_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ptbr;
  logic        iv, dv, mrdy, rv;
  logic [29:0] ivpn, dvpn;
  logic [31:0] rdata;
  logic        irdy, drdy, mv;
  logic [31:0] maddr;
  logic        irv, ierr, drv, derr;
  logic [31:0] ippn, dppn;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ptw_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .io_ptbr(ptbr),
    .io_imem_req_valid(iv), .io_imem_req_ready(irdy), .io_imem_req_bits_vpn(ivpn),
    .io_dmem_req_valid(dv), .io_dmem_req_ready(drdy), .io_dmem_req_bits_vpn(dvpn),
    .io_mem_req_valid(mv), .io_mem_req_ready(mrdy), .io_mem_req_bits_addr(maddr),
    .io_mem_resp_valid(rv), .io_mem_resp_bits_data(rdata),
    .io_imem_ptw_resp_valid(irv), .io_imem_ptw_resp_bits_error(ierr), .io_imem_ptw_resp_bits_ppn(ippn),
    .io_dmem_ptw_resp_valid(drv), .io_dmem_ptw_resp_bits_error(derr), .io_dmem_ptw_resp_bits_ppn(dppn)
  );

  typedef struct {
    logic iv; logic [29:0] ivpn; logic dv; logic [29:0] dvpn;
    logic mrdy; logic rv; logic [31:0] rdata;
    logic e_irdy; logic e_drdy; logic e_mv; logic [31:0] e_addr;
    logic e_irv; logic e_ierr; logic [31:0] e_ippn;
    logic e_drv; logic e_derr; logic [31:0] e_dppn;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic e_irv, input logic e_ierr, input logic [31:0] e_ippn,
                          input logic e_drv, input logic e_derr, input logic [31:0] e_dppn);
    chk({tag, " imem_resp_valid"}, {31'd0, irv}, {31'd0, e_irv});
    chk({tag, " imem_resp_error"}, {31'd0, ierr}, {31'd0, e_ierr});
    chk({tag, " imem_resp_ppn"}, ippn, e_ippn);
    chk({tag, " dmem_resp_valid"}, {31'd0, drv}, {31'd0, e_drv});
    chk({tag, " dmem_resp_error"}, {31'd0, derr}, {31'd0, e_derr});
    chk({tag, " dmem_resp_ppn"}, dppn, e_dppn);
  endtask

  task automatic idle_inputs();
    iv = 0; dv = 0; ivpn = '0; dvpn = '0; mrdy = 1; rv = 0; rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // cycle table: imem walk (valid PTE), dmem walk (invalid PTE), with a request during RESP and a stray response in REQ
    vecs[0] = '{1, 30'h5, 0, 30'h0, 1, 0, 32'h0,        1, 0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0};
    vecs[1] = '{0, 30'h0, 0, 30'h0, 1, 0, 32'h0,        0, 0, 1, 32'h1014, 0, 0, 32'h0,     0, 0, 32'h0};
    vecs[2] = '{0, 30'h0, 0, 30'h0, 1, 1, 32'h12345C01, 0, 0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0};
    vecs[3] = '{0, 30'h0, 1, 30'h3, 1, 0, 32'h0,        0, 0, 0, 32'h0,    1, 0, 32'h48D17, 0, 0, 32'h0};
    vecs[4] = '{0, 30'h0, 1, 30'h3, 1, 0, 32'h0,        0, 1, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0};
    vecs[5] = '{0, 30'h0, 0, 30'h0, 1, 1, 32'h12345C01, 0, 0, 1, 32'h100C, 0, 0, 32'h0,     0, 0, 32'h0};
    vecs[6] = '{0, 30'h0, 0, 30'h0, 1, 0, 32'h0,        0, 0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0};
    vecs[7] = '{0, 30'h0, 0, 30'h0, 1, 1, 32'h00000400, 0, 0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0};
    vecs[8] = '{0, 30'h0, 0, 30'h0, 1, 0, 32'h0,        0, 0, 0, 32'h0,    0, 0, 32'h0,     1, 1, 32'h0};
    vecs[9] = '{0, 30'h0, 0, 30'h0, 1, 0, 32'h0,        0, 0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 32'h0};

    ptbr = 32'h1000;
    idle_inputs();
    iv = 1; dv = 1;
    reset = 1;
    @(negedge clk);
    chk("reset imem_ready", {31'd0, irdy}, 32'd0);
    chk("reset dmem_ready", {31'd0, drdy}, 32'd0);
    chk("reset mem_valid", {31'd0, mv}, 32'd0);
    chk_resp("reset", 0, 0, 0, 0, 0, 0);
    tick();
    reset = 0;
    idle_inputs();

    for (int i = 0; i < 10; i++) begin
      iv = vecs[i].iv; ivpn = vecs[i].ivpn; dv = vecs[i].dv; dvpn = vecs[i].dvpn;
      mrdy = vecs[i].mrdy; rv = vecs[i].rv; rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d imem_ready", i), {31'd0, irdy}, {31'd0, vecs[i].e_irdy});
      chk($sformatf("vec%0d dmem_ready", i), {31'd0, drdy}, {31'd0, vecs[i].e_drdy});
      chk($sformatf("vec%0d mem_valid", i), {31'd0, mv}, {31'd0, vecs[i].e_mv});
      if (vecs[i].e_mv) chk($sformatf("vec%0d mem_addr", i), maddr, vecs[i].e_addr);
      chk_resp($sformatf("vec%0d", i), vecs[i].e_irv, vecs[i].e_ierr, vecs[i].e_ippn,
               vecs[i].e_drv, vecs[i].e_derr, vecs[i].e_dppn);
      tick();
    end

    // round robin after reset: both valid for three walks -> imem, dmem, imem
    reset = 1; #1; reset = 0;
    idle_inputs();
    iv = 1; ivpn = 30'h1; dv = 1; dvpn = 30'h2;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      chk($sformatf("rr%0d imem_ready", w), {31'd0, irdy}, {31'd0, w != 1});
      chk($sformatf("rr%0d dmem_ready", w), {31'd0, drdy}, {31'd0, w == 1});
      tick();
      @(negedge clk);
      chk($sformatf("rr%0d mem_addr", w), maddr, (w == 1) ? 32'h1008 : 32'h1004);
      chk($sformatf("rr%0d ready_low_in_req", w), {30'd0, irdy, drdy}, 32'd0);
      tick();
      rv = 1; rdata = 32'h00000C01;
      tick();
      rv = 0;
      @(negedge clk);
      chk_resp($sformatf("rr%0d", w), w != 1, 0, (w != 1) ? 32'h3 : 32'h0, w == 1, 0, (w == 1) ? 32'h3 : 32'h0);
      tick();
    end
    idle_inputs();

    // timeout: no response for 4 WAIT cycles, then a late response is ignored
    iv = 1; ivpn = 30'h7;
    tick();
    iv = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("tmo wait%0d imem_resp_valid", k), {31'd0, irv}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk_resp("tmo resp", 1, 1, 0, 0, 0, 0);
    tick();
    rv = 1; rdata = 32'h12345C01;
    @(negedge clk);
    chk_resp("tmo late", 0, 0, 0, 0, 0, 0);
    tick();
    rv = 0;
    @(negedge clk);
    chk_resp("tmo late+1", 0, 0, 0, 0, 0, 0);
    chk("tmo late mem_valid", {31'd0, mv}, 32'd0);

    // response arriving in the last WAIT cycle beats the timeout
    iv = 1; ivpn = 30'h8;
    tick();
    iv = 0;
    tick();
    tick(); tick(); tick();
    rv = 1; rdata = 32'h00001401;
    tick();
    rv = 0;
    @(negedge clk);
    chk_resp("race resp", 1, 0, 32'h5, 0, 0, 0);
    tick();

    // backpressure: mem_req_ready low for 3 cycles
    dv = 1; dvpn = 30'h10; mrdy = 0;
    tick();
    dv = 0; iv = 1; ivpn = 30'h1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d mem_valid", k), {31'd0, mv}, 32'd1);
      chk($sformatf("bp%0d mem_addr", k), maddr, 32'h1040);
      chk($sformatf("bp%0d imem_ready", k), {31'd0, irdy}, 32'd0);
      tick();
    end
    mrdy = 1;
    @(negedge clk);
    chk("bp release mem_valid", {31'd0, mv}, 32'd1);
    tick();
    iv = 0; rv = 1; rdata = 32'h00000801;
    tick();
    rv = 0;
    @(negedge clk);
    chk_resp("bp resp", 0, 0, 0, 1, 0, 32'h2);
    tick();

    // reset mid-WAIT, stray response afterwards, then a clean walk
    iv = 1; ivpn = 30'h7;
    tick();
    iv = 1;
    tick();
    #2 reset = 1;
    #1;
    chk("rst mem_valid", {31'd0, mv}, 32'd0);
    chk("rst imem_ready", {31'd0, irdy}, 32'd0);
    chk_resp("rst", 0, 0, 0, 0, 0, 0);
    tick();
    reset = 0; iv = 0; rv = 1; rdata = 32'h12345C01;
    @(negedge clk);
    chk_resp("rst stray", 0, 0, 0, 0, 0, 0);
    chk("rst stray mem_valid", {31'd0, mv}, 32'd0);
    tick();
    rv = 0; iv = 1; ivpn = 30'h9;
    @(negedge clk);
    chk("post imem_ready", {31'd0, irdy}, 32'd1);
    tick();
    iv = 0;
    @(negedge clk);
    chk("post mem_addr", maddr, 32'h1024);
    tick();
    rv = 1; rdata = 32'hABCDE401;
    tick();
    rv = 0;
    @(negedge clk);
    chk_resp("post resp", 1, 0, 32'h2AF379, 0, 0, 0);
    tick();
    @(negedge clk);
    chk_resp("post idle", 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
